// File: rtl/char_motion_ctrl.sv
// char_motion_ctrl: per-frame player motion and sprite-frame selection.
// Buttons are sampled only on frame_tick. Walk, jump and gravity physics run
// once per frame with screen clamping, and the sprite-sheet offsets for the
// compositor are picked from the resulting state.
// Optional feature macro: CHAR_FACING_EN adds the facing_left output so the
// compositor can mirror the sprite.
//
// Handshake: there is no valid/ready pair. frame_tick is a one-cycle
// qualifier; every register loads only on a clk edge with frame_tick = 1, so
// all outputs change one cycle after the tick and hold for the rest of the
// frame. rst is asynchronous and overrides a coincident tick.

module char_motion_ctrl #(
  parameter int SCREEN_W   = 640,
  parameter int SPR_W      = 30,
  parameter int GROUND_Y   = 400,
  parameter int WALK_SPEED = 2,
  parameter int JUMP_VEL   = 12,
  parameter int GRAVITY    = 1,
  parameter int ANIM_DIV   = 8,
  parameter int START_X    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  output logic [9:0] char_x,
  output logic [9:0] char_y,
  output logic [9:0] anim_row,
  output logic [9:0] anim_col,
  output logic       airborne,
`ifdef CHAR_FACING_EN
  output logic       facing_left,
`endif
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WALK = 2'd1,
    S_JUMP = 2'd2,
    S_FALL = 2'd3
  } state_e;

  localparam int CNT_W = $clog2(ANIM_DIV + 1);

  localparam logic signed [10:0] X_MAX    = 11'(SCREEN_W - SPR_W);
  localparam logic signed [10:0] X_STEP   = 11'(WALK_SPEED);
  localparam logic signed [10:0] Y_GND    = 11'(GROUND_Y);
  localparam logic signed [10:0] Y_LAUNCH = 11'(JUMP_VEL);
  localparam logic signed [8:0]  V_MAX    = 9'(JUMP_VEL);
  localparam logic signed [8:0]  V_GRAV   = 9'(GRAVITY);
  localparam logic signed [7:0]  V_AFTER_LAUNCH = 8'(GRAVITY - JUMP_VEL);
  localparam logic [9:0]         X_RESET  = 10'(START_X);
  localparam logic [9:0]         Y_RESET  = 10'(GROUND_Y);
  localparam logic [CNT_W-1:0]   ANIM_DIV_C = CNT_W'(ANIM_DIV);
  // Sheet offsets: rows are 40 pixels apart, columns one sprite width apart.
  localparam logic [9:0]         ROW_OFF  = 10'd40;
  localparam logic [9:0]         COL_OFF  = 10'(SPR_W);

  state_e state_q, state_d;

  logic [9:0]        x_q, x_d;
  logic [9:0]        y_q, y_d;
  logic signed [7:0] vel_q, vel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        frame_q, frame_d;
  logic              jump_prev_q;
  logic [9:0]        anim_row_q, anim_row_d;
  logic [9:0]        anim_col_q, anim_col_d;
  logic              airborne_q, airborne_d;

  // Button decode: exactly one direction means motion; jump is edge-detected.
  logic move_l, move_r, one_dir, jump_req;
  assign move_l   = btn_left & ~btn_right;
  assign move_r   = btn_right & ~btn_left;
  assign one_dir  = move_l | move_r;
  assign jump_req = btn_jump & ~jump_prev_q;

  // Vertical arithmetic is done 11-bit signed so overshoot above the screen
  // top is visible as a negative value before clamping.
  logic signed [10:0] y_ext, vel_ext, y_sum, launch_y;
  logic signed [8:0]  vel_plus;
  assign y_ext    = $signed({1'b0, y_q});
  assign vel_ext  = {{3{vel_q[7]}}, vel_q};
  assign y_sum    = y_ext + vel_ext;
  assign launch_y = y_ext - Y_LAUNCH;
  assign vel_plus = $signed({vel_q[7], vel_q}) + V_GRAV;

  // Horizontal motion: same rule in every state, clamped to the visible area.
  logic signed [10:0] x_step, x_sum;
  always_comb begin
    x_step = '0;
    if (move_r) begin
      x_step = X_STEP;
    end else if (move_l) begin
      x_step = -X_STEP;
    end
    x_sum = $signed({1'b0, x_q}) + x_step;
    if (x_sum < 11'sd0) begin
      x_d = '0;
    end else if (x_sum > X_MAX) begin
      x_d = X_MAX[9:0];
    end else begin
      x_d = x_sum[9:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else if (frame_tick) begin
      state_q <= state_d;
    end
  end

  // Next-state and vertical physics: launch, rise, fall and landing.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vel_d   = vel_q;
    case (state_q)
      S_IDLE, S_WALK: begin
        if (jump_req) begin
          // Launch velocity is applied on the same tick as the takeoff.
          y_d     = (launch_y < 11'sd0) ? 10'd0 : launch_y[9:0];
          vel_d   = V_AFTER_LAUNCH;
          state_d = S_JUMP;
        end else begin
          state_d = one_dir ? S_WALK : S_IDLE;
        end
      end
      S_JUMP: begin
        if (y_sum < 11'sd0) begin
          // Hit the screen top: stop rising and start falling from row 0.
          y_d     = '0;
          vel_d   = '0;
          state_d = S_FALL;
        end else begin
          y_d   = y_sum[9:0];
          vel_d = vel_plus[7:0];
          if (!vel_plus[8]) begin
            state_d = S_FALL;
          end
        end
      end
      S_FALL: begin
        if (y_sum >= Y_GND) begin
          y_d     = Y_GND[9:0];
          vel_d   = '0;
          state_d = one_dir ? S_WALK : S_IDLE;
        end else begin
          y_d   = y_sum[9:0];
          vel_d = (vel_plus > V_MAX) ? V_MAX[7:0] : vel_plus[7:0];
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode: animation frame and airborne flag for the upcoming state.
  logic             entering_walk;
  logic [CNT_W-1:0] cnt_base, cnt_inc;
  logic [1:0]       frame_base;
  always_comb begin
    entering_walk = (state_q != S_WALK);
    cnt_base      = entering_walk ? '0 : cnt_q;
    frame_base    = entering_walk ? 2'd0 : frame_q;
    cnt_inc       = cnt_base + 1'b1;
    cnt_d         = '0;
    frame_d       = 2'd0;
    case (state_d)
      S_WALK: begin
        if (cnt_inc == ANIM_DIV_C) begin
          cnt_d   = '0;
          frame_d = frame_base + 2'd1;
        end else begin
          cnt_d   = cnt_inc;
          frame_d = frame_base;
        end
      end
      S_JUMP, S_FALL: begin
        frame_d = 2'd3;
      end
      default: begin
        frame_d = 2'd0;
      end
    endcase
    anim_row_d = frame_d[1] ? ROW_OFF : 10'd0;
    anim_col_d = frame_d[0] ? COL_OFF : 10'd0;
    airborne_d = (state_d == S_JUMP) || (state_d == S_FALL);
  end

  // Datapath and registered outputs, loaded once per frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q         <= X_RESET;
      y_q         <= Y_RESET;
      vel_q       <= '0;
      cnt_q       <= '0;
      frame_q     <= 2'd0;
      jump_prev_q <= 1'b0;
      anim_row_q  <= '0;
      anim_col_q  <= '0;
      airborne_q  <= 1'b0;
    end else if (frame_tick) begin
      x_q         <= x_d;
      y_q         <= y_d;
      vel_q       <= vel_d;
      cnt_q       <= cnt_d;
      frame_q     <= frame_d;
      jump_prev_q <= btn_jump;
      anim_row_q  <= anim_row_d;
      anim_col_q  <= anim_col_d;
      airborne_q  <= airborne_d;
    end
  end

`ifdef CHAR_FACING_EN
  logic facing_q;
  // Facing follows the last single-direction press, in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      facing_q <= 1'b0;
    end else if (frame_tick) begin
      if (move_l) begin
        facing_q <= 1'b1;
      end else if (move_r) begin
        facing_q <= 1'b0;
      end
    end
  end
  assign facing_left = facing_q;
`endif

  assign char_x    = x_q;
  assign char_y    = y_q;
  assign anim_row  = anim_row_q;
  assign anim_col  = anim_col_q;
  assign airborne  = airborne_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_char_motion_ctrl.sv
// Bench for char_motion_ctrl: directed walk/clamp/jump/reset scenarios plus
// randomized button streams checked against a behavioural model.
module tb_char_motion_ctrl;

  // Clock and reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       frame_tick, tick2;
  logic       btn_left, btn_right, btn_jump;
  logic [9:0] char_x, char_y, anim_row, anim_col;
  logic       airborne;
  logic [1:0] dbg_state;
  logic [9:0] x2, y2, row2, col2;
  logic       air2;
  logic [1:0] dbg2;
`ifdef CHAR_FACING_EN
  logic       facing_left, face2;
`endif

  char_motion_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_jump   (btn_jump),
    .char_x     (char_x),
    .char_y     (char_y),
    .anim_row   (anim_row),
    .anim_col   (anim_col),
    .airborne   (airborne),
`ifdef CHAR_FACING_EN
    .facing_left(facing_left),
`endif
    .dbg_state  (dbg_state)
  );

  // Second instance starting near the right edge for the clamp scenario.
  char_motion_ctrl #(.START_X(600)) dut_edge (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (tick2),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_jump   (btn_jump),
    .char_x     (x2),
    .char_y     (y2),
    .anim_row   (row2),
    .anim_col   (col2),
    .airborne   (air2),
`ifdef CHAR_FACING_EN
    .facing_left(face2),
`endif
    .dbg_state  (dbg2)
  );

  // Scoreboard counters
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Behavioural reference model. Airborne phase is told apart by the sign of
  // the vertical velocity (negative = rising); the walk animation frame is
  // derived from the length of the current uninterrupted walking run.
  int m_x, m_y, m_vel, m_walk_run;
  bit m_air, m_jprev, m_walking, m_face;

  task automatic model_reset();
    m_x = 0; m_y = 400; m_vel = 0; m_walk_run = 0;
    m_air = 0; m_jprev = 0; m_walking = 0; m_face = 0;
  endtask

  task automatic model_tick(input bit l, input bit r, input bit j);
    int nx, ny;
    bit req;
    nx = m_x + ((l && !r) ? -2 : ((r && !l) ? 2 : 0));
    m_x = (nx < 0) ? 0 : ((nx > 610) ? 610 : nx);
    req = j && !m_jprev;
    m_jprev = j;
    if (!m_air) begin
      if (req) begin
        m_vel = -12;
        m_y   = m_y + m_vel;
        m_vel = m_vel + 1;
        m_air = 1;
      end
    end else if (m_vel < 0) begin
      ny = m_y + m_vel;
      if (ny < 0) begin
        m_y = 0; m_vel = 0;
      end else begin
        m_y = ny; m_vel = m_vel + 1;
      end
    end else begin
      if (m_y + m_vel >= 400) begin
        m_y = 400; m_vel = 0; m_air = 0;
      end else begin
        m_y = m_y + m_vel;
        m_vel = (m_vel + 1 > 12) ? 12 : m_vel + 1;
      end
    end
    m_walking  = !m_air && (l != r);
    m_walk_run = m_walking ? m_walk_run + 1 : 0;
    if (l && !r) m_face = 1;
    else if (r && !l) m_face = 0;
  endtask

  task automatic compare_model(input string where);
    int frame, erow, ecol;
    if (m_air) begin
      erow = 40; ecol = 30;
    end else if (m_walking) begin
      frame = (m_walk_run / 8) % 4;
      erow = (frame >= 2) ? 40 : 0;
      ecol = (frame % 2 == 1) ? 30 : 0;
    end else begin
      erow = 0; ecol = 0;
    end
    check_eq({where, " char_x"},   char_x,   m_x);
    check_eq({where, " char_y"},   char_y,   m_y);
    check_eq({where, " anim_row"}, anim_row, erow);
    check_eq({where, " anim_col"}, anim_col, ecol);
    check_eq({where, " airborne"}, airborne, int'(m_air));
`ifdef CHAR_FACING_EN
    check_eq({where, " facing"},   facing_left, int'(m_face));
`endif
  endtask

  // Driver tasks
  task automatic do_tick(input bit l, input bit r, input bit j);
    @(negedge clk);
    btn_left = l; btn_right = r; btn_jump = j;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    model_tick(l, r, j);
  endtask

  task automatic do_tick_edge(input bit l, input bit r);
    @(negedge clk);
    btn_left = l; btn_right = r; btn_jump = 1'b0;
    tick2 = 1'b1;
    @(negedge clk);
    tick2 = 1'b0;
  endtask

  // Non-tick cycles with buttons toggling; nothing may change.
  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      btn_left  = 1'($urandom_range(0, 1));
      btn_right = 1'($urandom_range(0, 1));
      btn_jump  = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    int takeoffs;
    bit prev_air;
    bit l, r, j;
    int gap;

    // Reset held for 3 cycles with ticks running and a button pressed.
    rst = 1'b1; frame_tick = 1'b1; tick2 = 1'b1;
    btn_left = 1'b0; btn_right = 1'b1; btn_jump = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset char_x", char_x, 0);
    check_eq("reset char_y", char_y, 400);
    check_eq("reset anim_row", anim_row, 0);
    check_eq("reset anim_col", anim_col, 0);
    check_eq("reset airborne", airborne, 0);
    check_eq("reset edge char_x", x2, 600);
    rst = 1'b0; frame_tick = 1'b0; tick2 = 1'b0; btn_right = 1'b0;
    model_reset();

    // Walk right for 10 ticks with button noise between ticks.
    for (int k = 1; k <= 10; k++) begin
      do_tick(1'b0, 1'b1, 1'b0);
      compare_model("walk");
      if (k == 7) check_eq("walk tick7 anim_col", anim_col, 0);
      if (k == 8) check_eq("walk tick8 anim_col", anim_col, 30);
      idle_gap(2);
      compare_model("walk gap");
    end
    check_eq("walk final char_x", char_x, 20);

    // Asynchronous reset between ticks takes effect without a clock edge.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("async rst char_x", char_x, 0);
    check_eq("async rst anim_col", anim_col, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    compare_model("after rst");

    // Single-tick jump press: full arc.
    for (int t = 1; t <= 27; t++) begin
      do_tick(1'b0, 1'b0, t == 1);
      compare_model("arc");
      if (t == 1)  check_eq("arc t1 char_y", char_y, 388);
      if (t == 2)  check_eq("arc t2 char_y", char_y, 377);
      if (t == 12) check_eq("arc apex char_y", char_y, 322);
      if (t == 12) check_eq("arc apex anim_row", anim_row, 40);
      if (t == 24) check_eq("arc t24 airborne", airborne, 1);
      if (t == 25) check_eq("arc land char_y", char_y, 400);
      if (t == 25) check_eq("arc land airborne", airborne, 0);
    end

    // Held jump: exactly one arc, then release and press re-launches.
    takeoffs = 0;
    prev_air = 1'b0;
    for (int t = 0; t < 60; t++) begin
      do_tick(1'b0, 1'b0, 1'b1);
      compare_model("held");
      if (airborne && !prev_air) takeoffs++;
      prev_air = airborne;
    end
    check_eq("held takeoffs", takeoffs, 1);
    do_tick(1'b0, 1'b0, 1'b0);
    compare_model("release");
    do_tick(1'b0, 1'b0, 1'b1);
    compare_model("repress");
    check_eq("repress airborne", airborne, 1);
    check_eq("repress char_y", char_y, 388);

    // Right clamp on the second instance; main instance must stay frozen.
    for (int k = 1; k <= 10; k++) begin
      do_tick_edge(1'b0, 1'b1);
      check_eq("clamp char_x", x2, (600 + 2 * k > 610) ? 610 : 600 + 2 * k);
    end
    for (int k = 0; k < 2; k++) begin
      do_tick_edge(1'b1, 1'b1);
      check_eq("clamp both char_x", x2, 610);
    end
    compare_model("frozen");

    // Randomized button streams against the model.
    for (int i = 0; i < 400; i++) begin
      l = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      j = ($urandom_range(0, 3) == 0);
      do_tick(l, r, j);
      compare_model("rand");
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        idle_gap(gap);
        compare_model("rand gap");
      end
    end

`ifdef CHAR_FACING_EN
    do_tick(1'b1, 1'b0, 1'b0);
    check_eq("facing left", facing_left, 1);
    do_tick(1'b0, 1'b0, 1'b0);
    check_eq("facing idle", facing_left, 1);
    do_tick(1'b0, 1'b0, 1'b1);
    check_eq("facing jump", facing_left, 1);
    do_tick(1'b0, 1'b1, 1'b0);
    check_eq("facing right", facing_left, 0);
    compare_model("facing");
`endif

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/char_motion_ctrl.md
Name: char_motion_ctrl

Overview:
- Per-frame player motion and animation controller.
- Sits directly upstream of the sprite compositor in the top level, and feeds it char_x, char_y, anim_row and anim_col.
- Samples button inputs once per frame, on frame_tick from the VGA timing block.
- Applies walk, jump and gravity physics with screen clamping, and selects the sprite-sheet frame offset.

Parameters:
- SCREEN_W, 640, visible width in pixels
- SPR_W, 30, sprite width; right clamp is SCREEN_W-SPR_W = 610
- GROUND_Y, 400, top-left y of the sprite when standing
- WALK_SPEED, 2, horizontal pixels per frame
- JUMP_VEL, 12, initial upward speed; also the maximum fall speed
- GRAVITY, 1, velocity increment per frame
- ANIM_DIV, 8, frames per walk-animation step
- START_X, 0, reset x position

Ports:
- clk  in  1  pixel clock (PLL output)
- rst  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame
- btn_left  in  1  move left, level
- btn_right  in  1  move right, level
- btn_jump  in  1  jump, level
- char_x  out  10  sprite top-left column
- char_y  out  10  sprite top-left row
- anim_row  out  10  sheet row offset, value 0 or 40
- anim_col  out  10  sheet column offset, value 0 or 30
- airborne  out  1  high while in JUMP or FALL

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset values:
  - char_x = START_X, char_y = GROUND_Y
  - anim_row = 0, anim_col = 0, airborne = 0
  - state = IDLE, vel_y = 0, anim counter = 0, jump_prev = 0
- rst asserted mid-operation clears everything immediately; rst wins over a coincident frame_tick.
- Update timing:
  - All state and outputs are registered and update only on edges where frame_tick = 1, giving 1-cycle latency from the tick.
  - Outputs are held stable for the rest of the frame. Buttons sampled with frame_tick = 0 are ignored.
- Horizontal motion, every tick in any state:
  - left XOR right: x ±= WALK_SPEED.
  - Both or neither pressed: no move.
  - Compute in 11-bit signed and clamp to [0, 610]; for example, x = 1 moving left gives 0.
- Jump edge detect: jump_prev <= btn_jump on each tick. A jump is requested only if btn_jump = 1 and jump_prev = 0.
- State machine: IDLE, WALK, JUMP, FALL, with vel_y an 8-bit signed register (negative = up).
  - IDLE/WALK:
    - With a jump request: vel_y := -JUMP_VEL, y += vel_y on the same tick, vel_y += GRAVITY, go to JUMP.
    - Otherwise go to WALK if exactly one direction is pressed, else IDLE.
  - JUMP: y += vel_y, then vel_y += GRAVITY. When the new vel_y >= 0, go to FALL. If y would go below 0, clamp y to 0, set vel_y = 0, go to FALL.
  - FALL:
    - If y + vel_y >= GROUND_Y: y := GROUND_Y, vel_y := 0, go to IDLE or WALK per the buttons.
    - Otherwise y += vel_y and vel_y := min(vel_y + GRAVITY, JUMP_VEL).
  - Jump requests in JUMP/FALL are ignored, but jump_prev still tracks the button.
- Animation frames: f0 = (row 0, col 0), f1 = (0, 30), f2 = (40, 0), f3 = (40, 30).
  - IDLE: f0.
  - WALK: counter increments every tick; on reaching ANIM_DIV it resets and the frame advances f0→f1→f2→f3→f0. Entering WALK from another state resets the frame to f0 and the counter to 0.
  - JUMP/FALL: f3.
- airborne = 1 exactly when the registered state is JUMP or FALL.

Optional Feature:
- Macro: CHAR_FACING_EN.
- When defined:
  - Adds output facing_left (1 bit), reset 0.
  - Set to 1 on a tick with left-only pressed, cleared on a tick with right-only pressed, held otherwise, in all states.
  - The compositor uses it to mirror the sprite.
- When undefined: the port and its register are absent, and all other behaviour is identical.

Test Plan:
- Reset: pulse rst for 3 cycles with frame_tick running -> char_x = 0, char_y = 400, anim = (0,0), airborne = 0. rst asserted between ticks clears x immediately, without waiting for a clock edge.
- Walk: hold btn_right for 10 ticks -> char_x = 20.
  - anim (0,0) for ticks 1-7, (0,30) at tick 8.
  - Toggling buttons with frame_tick low changes nothing.
- Right clamp: START_X = 600, hold right for 10 ticks -> char_x = 602, 604, … 610, then stays 610. Holding left and right together -> no change.
- Jump arc: one-tick jump press on the ground.
  - char_y 388 after tick 1, 377 after tick 2; apex 322 after tick 12; lands 400 at tick 25.
  - airborne is high for ticks 1-24 and low from tick 25; anim = (40,30) while airborne.
- Held jump: hold btn_jump for 60 ticks -> exactly one arc, no re-jump after landing. Release for one tick, then press again -> a new jump starts.
- CHAR_FACING_EN: left for 1 tick -> facing_left = 1; idle and jump -> stays 1; right for 1 tick -> 0.
